rabbit_ctrl: RTL

Sequencer for the Rabbit cipher core: drives the 8-lane state-update datapath and its counter system through key setup, counter re-initialisation, optional IV setup and keystream generation. Issues one-cycle load and iterate strobes to the datapath. Presents each 128-bit keystream block extraction point to a consumer via a valid/ready handshake. Contains no cipher arithmetic, only control.

---
 rtl/rabbit_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rabbit_ctrl.sv
// Rabbit cipher sequencer: key setup, counter re-init, optional IV setup, keystream handshake.
// Optional block counter output enabled by defining RABBIT_CTRL_BLKCNT_EN.
module rabbit_ctrl #(
    parameter int unsigned SETUP_ROUNDS = 4,
    parameter int unsigned RND_W        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             iv_en,
    input  logic             stop,
    input  logic             ks_ready,
    output logic             key_load,
    output logic             ctr_reinit,
    output logic             iv_load,
    output logic             su_en,
    output logic             ks_valid,
    output logic             busy,
`ifdef RABBIT_CTRL_BLKCNT_EN
    output logic [31:0]      blk_cnt,
`endif
    output logic [RND_W-1:0] round_cnt
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_KEY_LOAD   = 3'd1;
    localparam logic [2:0] S_KEY_ITER   = 3'd2;
    localparam logic [2:0] S_CTR_REINIT = 3'd3;
    localparam logic [2:0] S_IV_LOAD    = 3'd4;
    localparam logic [2:0] S_IV_ITER    = 3'd5;
    localparam logic [2:0] S_GEN        = 3'd6;
    localparam logic [2:0] S_KS_VALID   = 3'd7;

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(SETUP_ROUNDS - 1);

    logic [2:0]       state;
    logic [2:0]       nxt;
    logic             iv_flag;
    logic             iv_flag_d;
    logic [RND_W-1:0] rnd_d;
    logic             key_load_d;
    logic             ctr_reinit_d;
    logic             iv_load_d;
    logic             su_en_d;
    logic             ks_valid_d;
    logic             busy_d;

    // Next-state, round index and Moore output decode from the next state
    always_comb begin
        nxt          = state;
        iv_flag_d    = iv_flag;
        rnd_d        = '0;
        key_load_d   = 1'b0;
        ctr_reinit_d = 1'b0;
        iv_load_d    = 1'b0;
        su_en_d      = 1'b0;
        ks_valid_d   = 1'b0;
        busy_d       = 1'b0;

        if (stop) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        nxt       = S_KEY_LOAD;
                        iv_flag_d = iv_en;
                    end
                end
                S_KEY_LOAD:   nxt = S_KEY_ITER;
                S_KEY_ITER: begin
                    if (round_cnt == LAST_RND) nxt = S_CTR_REINIT;
                    else rnd_d = RND_W'(round_cnt + 1'b1);
                end
                S_CTR_REINIT: nxt = iv_flag ? S_IV_LOAD : S_GEN;
                S_IV_LOAD:    nxt = S_IV_ITER;
                S_IV_ITER: begin
                    if (round_cnt == LAST_RND) nxt = S_GEN;
                    else rnd_d = RND_W'(round_cnt + 1'b1);
                end
                S_GEN:        nxt = S_KS_VALID;
                S_KS_VALID: begin
                    // Rekey wins over a same-cycle transfer; the pending block is dropped
                    if (start) begin
                        nxt       = S_KEY_LOAD;
                        iv_flag_d = iv_en;
                    end else if (ks_ready) begin
                        nxt = S_GEN;
                    end
                end
                default:      nxt = S_IDLE;
            endcase
        end

        key_load_d   = (nxt == S_KEY_LOAD);
        ctr_reinit_d = (nxt == S_CTR_REINIT);
        iv_load_d    = (nxt == S_IV_LOAD);
        su_en_d      = (nxt == S_KEY_ITER) || (nxt == S_IV_ITER) || (nxt == S_GEN);
        ks_valid_d   = (nxt == S_KS_VALID);
        busy_d       = (nxt != S_IDLE) && (nxt != S_KS_VALID);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            iv_flag    <= 1'b0;
            round_cnt  <= '0;
            key_load   <= 1'b0;
            ctr_reinit <= 1'b0;
            iv_load    <= 1'b0;
            su_en      <= 1'b0;
            ks_valid   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= nxt;
            iv_flag    <= iv_flag_d;
            round_cnt  <= rnd_d;
            key_load   <= key_load_d;
            ctr_reinit <= ctr_reinit_d;
            iv_load    <= iv_load_d;
            su_en      <= su_en_d;
            ks_valid   <= ks_valid_d;
            busy       <= busy_d;
        end
    end

`ifdef RABBIT_CTRL_BLKCNT_EN
    logic xfer_c;
    assign xfer_c = (state == S_KS_VALID) && ks_ready && !start && !stop;

    // Saturating count of accepted blocks since the last key load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (key_load_d) begin
            blk_cnt <= '0;
        end else if (xfer_c && (blk_cnt != 32'hFFFF_FFFF)) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end
`endif

endmodule
